// File: rtl/dip_pkg.sv
// rtl/dip_pkg.sv - shared widths, frame type and FSM state encoding for the DIP frame qualifier
package dip_pkg;

    localparam int DIP_DATA_W  = 16;
    localparam int DIP_CTRL_W  = 5;
    localparam int DIP_FRAME_W = DIP_CTRL_W + DIP_DATA_W;

    // One complete reader frame: control switches above the DIP word (ctrl bit0 = s3)
    typedef struct packed {
        logic [DIP_CTRL_W-1:0] ctrl;
        logic [DIP_DATA_W-1:0] data;
    } dip_frame_t;

    typedef enum logic [1:0] {
        S_WAIT_FIRST = 2'd0,
        S_QUALIFY    = 2'd1,
        S_STABLE     = 2'd2
    } dipq_state_t;

endpackage

// File: rtl/dip_frame_qualifier_if.sv
// rtl/dip_frame_qualifier_if.sv - qualified-value valid/ready channel towards the CPU front-end
interface dip_frame_qualifier_if;
    import dip_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [DIP_DATA_W-1:0] out_data;
    logic [DIP_CTRL_W-1:0] out_ctrl;

    // Qualifier side drives the value, consumer drives ready
    modport master (output out_valid, output out_data, output out_ctrl, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ctrl, output out_ready);

endinterface

// File: rtl/dip_latch_edge.sv
// rtl/dip_latch_edge.sv - registers latch and frame together and flags the latch falling edge
module dip_latch_edge
    import dip_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lat_i,
    input  dip_frame_t frame_i,
    output dip_frame_t frame_o,
    output logic       frame_end_o
);

    logic       lat_q;
    logic       lat_qq;
    dip_frame_t frame_q;

    // Capture latch and frame on the same edge so the frame matches the latch sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q   <= 1'b0;
            lat_qq  <= 1'b0;
            frame_q <= '0;
        end else begin
            lat_q   <= lat_i;
            lat_qq  <= lat_q;
            frame_q <= frame_i;
        end
    end

    // Only the 1->0 step counts, so a long low pulse is a single frame
    assign frame_end_o = lat_qq & ~lat_q;
    assign frame_o     = frame_q;

endmodule

// File: rtl/dip_frame_qualifier.sv
// rtl/dip_frame_qualifier.sv - debounces DIP reader frames and hands stable values out; optional DIPCAP_TIMEOUT_EN link timeout
module dip_frame_qualifier
    import dip_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dip_latch,
    input  logic [DIP_DATA_W-1:0] dip_data,
    input  logic [DIP_CTRL_W-1:0] dip_ctrl,
    dip_frame_qualifier_if.master out_if,
    output logic                  overrun,
    input  logic                  clr_overrun,
    output logic                  link_lost
);

    localparam int                CNT_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  SF_C  = CNT_W'(STABLE_FRAMES);

    if (STABLE_FRAMES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dip_frame_qualifier: STABLE_FRAMES and TIMEOUT_CYCLES must be >= 1");
    end

    dip_frame_t  frame_in;
    dip_frame_t  frame;
    logic        frame_end;
    logic        tmo_hit;

    dipq_state_t      state_q, state_d;
    dip_frame_t       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dip_frame_t       committed_q;
    logic             first_q;
    logic             valid_q;
    dip_frame_t       out_q;
    logic             overrun_q;
    logic             eligible;
    logic             commit;
    logic             blocked;

    assign frame_in = {dip_ctrl, dip_data};

    dip_latch_edge u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .lat_i       (dip_latch),
        .frame_i     (frame_in),
        .frame_o     (frame),
        .frame_end_o (frame_end)
    );

    // Qualification FSM: candidate tracking, stability count and commit decision
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        eligible = 1'b0;
        commit   = 1'b0;
        blocked  = 1'b0;
        if (frame_end) begin
            case (state_q)
                S_WAIT_FIRST: begin
                    cand_d  = frame;
                    cnt_d   = CNT_W'(1);
                    state_d = S_QUALIFY;
                end
                S_QUALIFY: begin
                    if (frame == cand_q) begin
                        if (cnt_q != SF_C) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cand_d = frame;
                        cnt_d  = CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (frame != cand_q) begin
                        cand_d  = frame;
                        cnt_d   = CNT_W'(1);
                        state_d = S_QUALIFY;
                    end
                end
                default: state_d = S_WAIT_FIRST;
            endcase
            // The very first value after reset commits even if it equals the zeroed committed reg
            eligible = (state_d == S_QUALIFY) && (cnt_d == SF_C) &&
                       ((cand_d != committed_q) || first_q);
        end
        commit  = eligible && (!valid_q || out_if.out_ready);
        blocked = eligible && valid_q && !out_if.out_ready;
        if (commit) state_d = S_STABLE;
        // Losing the link restarts qualification; pending output is left alone
        if (tmo_hit) begin
            state_d = S_WAIT_FIRST;
            cnt_d   = '0;
        end
    end

    // FSM, candidate and committed value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT_FIRST;
            cand_q      <= '0;
            cnt_q       <= '0;
            committed_q <= '0;
            first_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                committed_q <= cand_d;
                first_q     <= 1'b0;
            end
        end
    end

    // Output handshake: data only moves on commit, which never happens while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (commit) begin
            valid_q <= 1'b1;
            out_q   <= cand_d;
        end else if (valid_q && out_if.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (blocked) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef DIPCAP_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_C    = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             link_lost_q;

    assign tmo_hit = !frame_end && (tmo_cnt_q == TMO_LAST);

    // Frame-gap counter; saturates so link_lost fires once per outage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= '0;
            link_lost_q <= 1'b0;
        end else if (frame_end) begin
            tmo_cnt_q   <= '0;
            link_lost_q <= 1'b0;
        end else if (tmo_cnt_q != TMO_C) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (tmo_hit) link_lost_q <= 1'b1;
        end
    end

    assign link_lost = link_lost_q;
`else
    assign tmo_hit   = 1'b0;
    assign link_lost = 1'b0;
`endif

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = out_q.data;
    assign out_if.out_ctrl  = out_q.ctrl;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_dip_frame_qualifier.sv
// tb/tb_dip_frame_qualifier.sv - directed self-checking bench for dip_frame_qualifier
module tb_dip_frame_qualifier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dip_latch = 1'b1;
    logic [15:0] dip_data = '0;
    logic [4:0]  dip_ctrl = '0;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic        link_lost;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    dip_frame_qualifier_if ifc ();

    dip_frame_qualifier #(.STABLE_FRAMES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dip_latch   (dip_latch),
        .dip_data    (dip_data),
        .dip_ctrl    (dip_ctrl),
        .out_if      (ifc.master),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .link_lost   (link_lost)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dip_latch = 1'b1;
        clr_overrun = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present a frame then pull the latch low for nlow cycles; returns just before the FSM edge
    task automatic send_frame(input logic [15:0] d, input logic [4:0] c, input int nlow);
        @(negedge clk);
        dip_latch = 1'b1;
        dip_data = d;
        dip_ctrl = c;
        @(negedge clk);
        dip_latch = 1'b0;
        repeat (nlow) @(negedge clk);
        dip_latch = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'h0) $display("FAIL rst_data got %h exp 0000", ifc.out_data); else pass_cnt++;
        total_cnt++; if (ifc.out_ctrl !== 5'h0) $display("FAIL rst_ctrl got %h exp 00", ifc.out_ctrl); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else pass_cnt++;
        total_cnt++; if (link_lost !== 1'b0) $display("FAIL rst_link_lost got %b exp 0", link_lost); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL basic_early got %b exp 0", ifc.out_valid); else pass_cnt++;
        send_frame(16'hA5C3, 5'h11, 1);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL basic_latency got %b exp 0", ifc.out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'hA5C3) $display("FAIL basic_data got %h exp a5c3", ifc.out_data); else pass_cnt++;
        total_cnt++; if (ifc.out_ctrl !== 5'h11) $display("FAIL basic_ctrl got %h exp 11", ifc.out_ctrl); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL basic_accept got %b exp 0", ifc.out_valid); else pass_cnt++;
    endtask

    task automatic test_debounce();
        logic [15:0] seq [7];
        logic        exp_v [7];
        seq   = '{16'hA5C3, 16'hA5C3, 16'h1234, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3};
        exp_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_frame(seq[i], 5'h11, (i == 4) ? 3 : 1);
            @(negedge clk);
            total_cnt++; if (ifc.out_valid !== exp_v[i]) $display("FAIL debounce_valid[%0d] got %b exp %b", i, ifc.out_valid, exp_v[i]); else pass_cnt++;
        end
        total_cnt++; if (ifc.out_data !== 16'hA5C3) $display("FAIL debounce_data got %h exp a5c3", ifc.out_data); else pass_cnt++;
        send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL debounce_no_overrun got %b exp 0", overrun); else pass_cnt++;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(16'hA5C3, 5'h11, 1);
        for (int i = 0; i < 4; i++) send_frame(16'h0F0F, 5'h00, 1);
        @(negedge clk);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b exp 1", overrun); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'hA5C3) $display("FAIL ovr_hold_data got %h exp a5c3", ifc.out_data); else pass_cnt++;
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL ovr_hold_valid got %b exp 1", ifc.out_valid); else pass_cnt++;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL ovr_drop got %b exp 0", ifc.out_valid); else pass_cnt++;
        send_frame(16'h0F0F, 5'h00, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL ovr_requal_valid got %b exp 1", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'h0F0F) $display("FAIL ovr_requal_data got %h exp 0f0f", ifc.out_data); else pass_cnt++;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", overrun); else pass_cnt++;
        for (int i = 0; i < 3; i++) send_frame(16'h1111, 5'h03, 1);
        clr_overrun = 1'b1;
        send_frame(16'h1111, 5'h03, 1);
        @(negedge clk);
        clr_overrun = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b exp 1", overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(16'hA5C3, 5'h11, 1);
        for (int i = 0; i < 4; i++) send_frame(16'h0F0F, 5'h04, 1);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'h0F0F) $display("FAIL b2b_data got %h exp 0f0f", ifc.out_data); else pass_cnt++;
        total_cnt++; if (ifc.out_ctrl !== 5'h04) $display("FAIL b2b_ctrl got %h exp 04", ifc.out_ctrl); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b exp 0", overrun); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL b2b_hold got %b exp 1", ifc.out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(16'hA5C3, 5'h11, 1);
        for (int i = 0; i < 3; i++) send_frame(16'h0F0F, 5'h00, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'h0) $display("FAIL midrst_data got %h exp 0000", ifc.out_data); else pass_cnt++;
        total_cnt++; if (ifc.out_ctrl !== 5'h0) $display("FAIL midrst_ctrl got %h exp 00", ifc.out_ctrl); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(16'h0F0F, 5'h00, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL midrst_fresh got %b exp 0", ifc.out_valid); else pass_cnt++;
        send_frame(16'h0F0F, 5'h00, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL midrst_commit got %b exp 1", ifc.out_valid); else pass_cnt++;
        total_cnt++; if (ifc.out_data !== 16'h0F0F) $display("FAIL midrst_data2 got %h exp 0f0f", ifc.out_data); else pass_cnt++;
    endtask

    task automatic test_link();
        do_reset();
        for (int i = 0; i < 2; i++) send_frame(16'hA5C3, 5'h11, 1);
        repeat (40) @(negedge clk);
        total_cnt++; if (link_lost !== 1'b0) $display("FAIL link_early got %b exp 0", link_lost); else pass_cnt++;
        repeat (30) @(negedge clk);
`ifdef DIPCAP_TIMEOUT_EN
        total_cnt++; if (link_lost !== 1'b1) $display("FAIL link_lost got %b exp 1", link_lost); else pass_cnt++;
        send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (link_lost !== 1'b0) $display("FAIL link_clear got %b exp 0", link_lost); else pass_cnt++;
        for (int i = 0; i < 2; i++) send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL link_requal got %b exp 0", ifc.out_valid); else pass_cnt++;
        send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL link_commit got %b exp 1", ifc.out_valid); else pass_cnt++;
`else
        total_cnt++; if (link_lost !== 1'b0) $display("FAIL link_tied got %b exp 0", link_lost); else pass_cnt++;
        for (int i = 0; i < 2; i++) send_frame(16'hA5C3, 5'h11, 1);
        @(negedge clk);
        total_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL link_wait got %b exp 1", ifc.out_valid); else pass_cnt++;
`endif
    endtask

    initial begin
        ifc.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_debounce();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_link();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
